// File: rtl/ws281x_pkg.sv
// Shared types and default timing for the WS281x driver/receiver pair.
// Cycle counts assume a 25 MHz clock.
package ws281x_pkg;

  localparam int unsigned WS281xWordWidth = 24;

  // Receiver decode thresholds.
  localparam int unsigned WS281xBitThreshCycles = 15;
  localparam int unsigned WS281xMinHighCycles   = 3;
  localparam int unsigned WS281xMaxHighCycles   = 50;
  localparam int unsigned WS281xResetCycles     = 1250;

  // Driver waveform: high time for a 0 and for a 1, and the full bit period.
  localparam int unsigned WS281xT0HCycles = 10;
  localparam int unsigned WS281xT1HCycles = 20;
  localparam int unsigned WS281xBitCycles = 31;

  typedef enum logic [1:0] {
    RESYNC,
    IDLE,
    HIGH,
    LOW
  } ws281x_rx_state_e;

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchroniser for bringing an asynchronous level into the clk domain.
module prim_flop_2sync #(
  parameter int unsigned      Width      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta;

  // NOTE: clocked state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, whatever the block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= ResetValue;
      q    <= ResetValue;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ws281x_rx.sv
// WS281x single-wire receiver: classifies high pulses by width into bits,
// packs 24-bit MSB-first words and flags the latch gap as a frame boundary.
module ws281x_rx
  import ws281x_pkg::*;
#(
  parameter int unsigned BitThreshCycles = WS281xBitThreshCycles,
  parameter int unsigned MinHighCycles   = WS281xMinHighCycles,
  parameter int unsigned MaxHighCycles   = WS281xMaxHighCycles,
  parameter int unsigned ResetCycles     = WS281xResetCycles
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       din_i,
  output logic [WS281xWordWidth-1:0] data_o,
  output logic                       data_valid_o,
  input  logic                       data_ready_i,
  output logic                       frame_end_o,
  output logic                       err_o,
  output logic                       overflow_o
);

  localparam int unsigned CntW = $clog2(ResetCycles + 1);

  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [CntW-1:0] HiSat  = CntW'(MaxHighCycles + 1);
  localparam logic [CntW-1:0] LoSat  = CntW'(ResetCycles);
  localparam logic [CntW-1:0] MinHi  = CntW'(MinHighCycles);
  localparam logic [CntW-1:0] MaxHi  = CntW'(MaxHighCycles);
  localparam logic [CntW-1:0] Thresh = CntW'(BitThreshCycles);
  localparam logic [4:0]      LastBit = 5'(WS281xWordWidth - 1);

  if (!(MinHighCycles < BitThreshCycles && BitThreshCycles <= MaxHighCycles &&
        MaxHighCycles < ResetCycles)) begin : g_bad_timing
    $error("ws281x_rx: need MinHighCycles < BitThreshCycles <= MaxHighCycles < ResetCycles");
  end

  logic                       s;
  logic                       prev;
  logic                       rise;
  logic                       fall;
  logic [CntW-1:0]            hi_cnt;
  logic [CntW-1:0]            lo_cnt;
  logic [CntW-1:0]            hi_next;
  logic [CntW-1:0]            lo_next;
  logic                       gap;
  logic                       stuck;
  logic                       bit_val;
  logic [4:0]                 bit_cnt;
  logic [WS281xWordWidth-1:0] shreg;
  logic [WS281xWordWidth-1:0] word;
  ws281x_rx_state_e           state;

  prim_flop_2sync #(
    .Width     (1),
    .ResetValue(1'b0)
  ) u_din_sync (
    .clk  (clk_i),
    .rst_n(rst_ni),
    .d    (din_i),
    .q    (s)
  );

  // Counter "next" values include the current cycle, so width and gap
  // decisions are taken in the cycle the condition first becomes true.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which is what would otherwise infer a latch.
  always_comb begin
    rise    = s & ~prev;
    fall    = ~s & prev;
    hi_next = hi_cnt;
    lo_next = lo_cnt;
    if (rise) begin
      hi_next = CntOne;
    end else if (s && hi_cnt != HiSat) begin
      hi_next = hi_cnt + CntOne;
    end
    if (fall) begin
      lo_next = CntOne;
    end else if (!s && lo_cnt != LoSat) begin
      lo_next = lo_cnt + CntOne;
    end
    gap     = ~s && (lo_next == LoSat);
    stuck   = s && (hi_next > MaxHi);
    bit_val = (hi_cnt >= Thresh);
    word    = {shreg[WS281xWordWidth-2:0], bit_val};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev   <= 1'b0;
      hi_cnt <= '0;
      lo_cnt <= '0;
    end else begin
      prev   <= s;
      hi_cnt <= hi_next;
      lo_cnt <= lo_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= RESYNC;
      bit_cnt      <= '0;
      shreg        <= '0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      frame_end_o  <= 1'b0;
      err_o        <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      frame_end_o <= 1'b0;
      err_o       <= 1'b0;
      overflow_o  <= 1'b0;

      // A delivery later in this block overrides this clear.
      if (data_valid_o && data_ready_i) begin
        data_valid_o <= 1'b0;
      end

      unique case (state)
        RESYNC: begin
          if (gap) begin
            frame_end_o <= 1'b1;
            state       <= IDLE;
          end
        end

        IDLE: begin
          if (rise) begin
            state <= HIGH;
          end
        end

        HIGH: begin
          if (fall) begin
            if (hi_cnt < MinHi) begin
              err_o   <= 1'b1;
              bit_cnt <= '0;
              state   <= RESYNC;
            end else begin
              shreg <= word;
              state <= LOW;
              if (bit_cnt == LastBit) begin
                bit_cnt <= '0;
                if (!data_valid_o || data_ready_i) begin
                  data_o       <= word;
                  data_valid_o <= 1'b1;
                end else begin
                  overflow_o <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end else if (stuck) begin
            err_o   <= 1'b1;
            bit_cnt <= '0;
            state   <= RESYNC;
          end
        end

        LOW: begin
          if (rise) begin
            state <= HIGH;
          end else if (gap) begin
            frame_end_o <= 1'b1;
            state       <= IDLE;
            if (bit_cnt != '0) begin
              err_o   <= 1'b1;
              bit_cnt <= '0;
            end
          end
        end

        default: state <= RESYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_ws281x_rx.sv
// Self-checking bench for ws281x_rx: drives WS281x waveforms cycle by cycle
// and compares against words and event counts derived from pulse widths.
module tb_ws281x_rx;
  import ws281x_pkg::*;

  localparam int Thresh = 15;
  localparam int MinH   = 3;
  localparam int MaxH   = 50;
  localparam int RstC   = 1250;
  localparam int Gap    = 1300;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic        ready = 1'b0;
  logic [23:0] data;
  logic        valid;
  logic        frame_end;
  logic        err;
  logic        overflow;

  always #5 clk = ~clk;

  ws281x_rx #(
    .BitThreshCycles(Thresh),
    .MinHighCycles  (MinH),
    .MaxHighCycles  (MaxH),
    .ResetCycles    (RstC)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .din_i       (din),
    .data_o      (data),
    .data_valid_o(valid),
    .data_ready_i(ready),
    .frame_end_o (frame_end),
    .err_o       (err),
    .overflow_o  (overflow)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled mid-cycle.
  int          fe_cnt = 0, err_cnt = 0, ovf_cnt = 0, vrise_cnt = 0;
  int          fe_cyc = 0, err_cyc = 0, vrise_cyc = 0;
  logic        v_q = 1'b0;
  logic [23:0] got[$];

  always @(negedge clk) begin
    if (frame_end) begin fe_cnt <= fe_cnt + 1; fe_cyc <= cyc; end
    if (err) begin err_cnt <= err_cnt + 1; err_cyc <= cyc; end
    if (overflow) ovf_cnt <= ovf_cnt + 1;
    if (valid && !v_q) begin vrise_cnt <= vrise_cnt + 1; vrise_cyc <= cyc; end
    v_q <= valid;
    if (valid && ready) got.push_back(data);
  end

  int pass_cnt = 0;
  int chk_cnt = 0;
  int last_fall = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Hold the line at v for n clock edges; changes land 1 ns after an edge.
  task automatic line(input logic v, input int n);
    din = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input int th, input int tl);
    line(1'b1, th);
    last_fall = cyc;
    line(1'b0, tl);
  endtask

  // Sends w; random widths stay clear of every threshold. exp is what a
  // receiver classifying each pulse by width must produce.
  task automatic send_word(input logic [23:0] w, input bit rnd, output logic [23:0] exp);
    int th, tl;
    exp = '0;
    for (int i = 23; i >= 0; i--) begin
      if (rnd) begin
        th = w[i] ? $urandom_range(MaxH - 1, Thresh + 1) : $urandom_range(Thresh - 2, MinH + 1);
        tl = $urandom_range(12, 2);
      end else begin
        th = w[i] ? WS281xT1HCycles : WS281xT0HCycles;
        tl = WS281xBitCycles - th;
      end
      exp = {exp[22:0], (th >= Thresh) ? 1'b1 : 1'b0};
      send_bit(th, tl);
    end
  endtask

  task automatic test_reset();
    int rel;
    din = 1'b0; ready = 1'b0; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++; if (data !== 24'h0) $display("FAIL reset_data: got %h expected 000000", data); else pass_cnt++;
    chk_cnt++; if ({valid, frame_end, err, overflow} !== 4'b0) $display("FAIL reset_flags: got %b expected 0000", {valid, frame_end, err, overflow}); else pass_cnt++;
    rst_n = 1'b1;
    rel = cyc;
    line(1'b0, RstC - 10);
    chk_cnt++; if (fe_cnt !== 0) $display("FAIL early_frame_end: got %0d expected 0", fe_cnt); else pass_cnt++;
    line(1'b0, Gap - RstC + 10);
    chk_cnt++; if (fe_cnt !== 1) $display("FAIL first_gap_count: got %0d expected 1", fe_cnt); else pass_cnt++;
    chk_cnt++; if (fe_cyc - rel !== RstC) $display("FAIL first_gap_time: got %0d expected %0d", fe_cyc - rel, RstC); else pass_cnt++;
  endtask

  task automatic test_single_word();
    logic [23:0] exp;
    int fe0, err0;
    fe0 = fe_cnt; err0 = err_cnt;
    ready = 1'b0;
    send_word(24'hA5C30F, 1'b0, exp);
    line(1'b0, Gap);
    chk_cnt++; if (data !== 24'hA5C30F) $display("FAIL single_data: got %h expected a5c30f", data); else pass_cnt++;
    chk_cnt++; if (valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", valid); else pass_cnt++;
    chk_cnt++; if (vrise_cyc - last_fall !== 3) $display("FAIL single_latency: got %0d expected 3", vrise_cyc - last_fall); else pass_cnt++;
    chk_cnt++; if (fe_cnt - fe0 !== 1) $display("FAIL single_frame_end: got %0d expected 1", fe_cnt - fe0); else pass_cnt++;
    chk_cnt++; if (fe_cyc - last_fall !== RstC + 2) $display("FAIL single_gap_time: got %0d expected %0d", fe_cyc - last_fall, RstC + 2); else pass_cnt++;
    chk_cnt++; if (err_cnt !== err0) $display("FAIL single_err: got %0d expected %0d", err_cnt, err0); else pass_cnt++;
    got.delete();
    ready = 1'b1;
    line(1'b0, 1);
    ready = 1'b0;
    chk_cnt++; if (valid !== 1'b0) $display("FAIL single_accept_clear: got %b expected 0", valid); else pass_cnt++;
    chk_cnt++; if (got.size() !== 1 || got[0] !== exp) $display("FAIL single_accept_word: got n=%0d expected %h", got.size(), exp); else pass_cnt++;
  endtask

  task automatic test_stream(input string name, input bit rnd, input int n, input logic [23:0] fixed[2]);
    logic [23:0] exp_q[$];
    logic [23:0] w, e;
    int err0, ovf0, fe0;
    err0 = err_cnt; ovf0 = ovf_cnt; fe0 = fe_cnt;
    got.delete();
    ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      w = rnd ? 24'($urandom()) : fixed[i % 2];
      send_word(w, rnd, e);
      exp_q.push_back(e);
    end
    line(1'b0, Gap);
    chk_cnt++; if (got.size() !== n) $display("FAIL %s_count: got %0d expected %0d", name, got.size(), n); else pass_cnt++;
    for (int i = 0; i < n && i < got.size(); i++) begin
      chk_cnt++; if (got[i] !== exp_q[i]) $display("FAIL %s_word%0d: got %h expected %h", name, i, got[i], exp_q[i]); else pass_cnt++;
    end
    chk_cnt++; if (err_cnt - err0 !== 0 || ovf_cnt - ovf0 !== 0) $display("FAIL %s_err_ovf: got %0d/%0d expected 0/0", name, err_cnt - err0, ovf_cnt - ovf0); else pass_cnt++;
    chk_cnt++; if (fe_cnt - fe0 !== 1) $display("FAIL %s_frame_end: got %0d expected 1", name, fe_cnt - fe0); else pass_cnt++;
  endtask

  // Pulses exactly at Min, Thresh-1, Thresh and Max decode without error.
  task automatic test_boundaries();
    int widths[4];
    logic [23:0] exp;
    int err0;
    widths = '{MinH, Thresh - 1, Thresh, MaxH};
    err0 = err_cnt;
    got.delete();
    ready = 1'b1;
    exp = '0;
    for (int i = 0; i < 24; i++) begin
      exp = {exp[22:0], (widths[i % 4] >= Thresh) ? 1'b1 : 1'b0};
      send_bit(widths[i % 4], 2);
    end
    line(1'b0, Gap);
    chk_cnt++; if (got.size() !== 1 || got[0] !== exp) $display("FAIL boundary_word: got n=%0d expected %h", got.size(), exp); else pass_cnt++;
    chk_cnt++; if (err_cnt !== err0) $display("FAIL boundary_err: got %0d expected %0d", err_cnt - err0, 0); else pass_cnt++;
  endtask

  task automatic test_glitch_stuck();
    logic [23:0] e1, e2;
    int err0, fe0;
    ready = 1'b1;
    got.delete();
    err0 = err_cnt; fe0 = fe_cnt;
    line(1'b1, 2);
    line(1'b0, 5);
    chk_cnt++; if (err_cnt - err0 !== 1) $display("FAIL glitch_err: got %0d expected 1", err_cnt - err0); else pass_cnt++;
    send_word(24'h5A5A5A, 1'b0, e1);
    chk_cnt++; if (got.size() !== 0 || err_cnt - err0 !== 1) $display("FAIL glitch_resync: got words=%0d errs=%0d expected 0/1", got.size(), err_cnt - err0); else pass_cnt++;
    line(1'b0, Gap);
    send_word(24'h0F0F0F, 1'b0, e2);
    line(1'b0, Gap);
    chk_cnt++; if (got.size() !== 1 || got[0] !== e2) $display("FAIL glitch_recover: got n=%0d expected %h", got.size(), e2); else pass_cnt++;
    chk_cnt++; if (fe_cnt - fe0 !== 2) $display("FAIL glitch_frame_end: got %0d expected 2", fe_cnt - fe0); else pass_cnt++;

    got.delete();
    err0 = err_cnt;
    line(1'b1, 60);
    line(1'b0, 100);
    chk_cnt++; if (err_cnt - err0 !== 1) $display("FAIL stuck_err: got %0d expected 1", err_cnt - err0); else pass_cnt++;
    send_word(24'h3C3C3C, 1'b0, e1);
    line(1'b0, Gap);
    chk_cnt++; if (got.size() !== 0 || err_cnt - err0 !== 1) $display("FAIL stuck_resync: got words=%0d errs=%0d expected 0/1", got.size(), err_cnt - err0); else pass_cnt++;
    send_word(24'hC3C3C3, 1'b0, e2);
    line(1'b0, Gap);
    chk_cnt++; if (got.size() !== 1 || got[0] !== e2) $display("FAIL stuck_recover: got n=%0d expected %h", got.size(), e2); else pass_cnt++;
  endtask

  task automatic test_partial();
    logic [23:0] e;
    int err0, fe0, vr0;
    ready = 1'b1;
    got.delete();
    err0 = err_cnt; fe0 = fe_cnt; vr0 = vrise_cnt;
    for (int i = 0; i < 12; i++) send_bit((i % 3 == 0) ? WS281xT1HCycles : WS281xT0HCycles, 11);
    line(1'b0, Gap);
    chk_cnt++; if (err_cnt - err0 !== 1 || fe_cnt - fe0 !== 1) $display("FAIL partial_counts: got err=%0d fe=%0d expected 1/1", err_cnt - err0, fe_cnt - fe0); else pass_cnt++;
    chk_cnt++; if (err_cyc !== fe_cyc) $display("FAIL partial_coincide: got err@%0d fe@%0d expected equal", err_cyc, fe_cyc); else pass_cnt++;
    chk_cnt++; if (vrise_cnt !== vr0) $display("FAIL partial_valid: got %0d rises expected 0", vrise_cnt - vr0); else pass_cnt++;
    send_word(24'($urandom()), 1'b1, e);
    line(1'b0, Gap);
    chk_cnt++; if (got.size() !== 1 || got[0] !== e) $display("FAIL partial_next_word: got n=%0d expected %h", got.size(), e); else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [23:0] a, b, c, ea, eb, ec;
    int ovf0, th;
    a = 24'($urandom()); b = 24'($urandom()); c = 24'($urandom());
    ready = 1'b0;
    got.delete();
    ovf0 = ovf_cnt;
    send_word(a, 1'b1, ea);
    send_word(b, 1'b1, eb);
    chk_cnt++; if (ovf_cnt - ovf0 !== 1) $display("FAIL ovf_pulse: got %0d expected 1", ovf_cnt - ovf0); else pass_cnt++;
    chk_cnt++; if (data !== ea || valid !== 1'b1) $display("FAIL ovf_retain: got %h v=%b expected %h v=1", data, valid, ea); else pass_cnt++;
    // Third word: ready rises exactly in the cycle its last bit is delivered.
    ec = '0;
    for (int i = 23; i >= 0; i--) begin
      th = c[i] ? WS281xT1HCycles : WS281xT0HCycles;
      ec = {ec[22:0], (th >= Thresh) ? 1'b1 : 1'b0};
      if (i > 0) send_bit(th, 11);
      else begin
        line(1'b1, th);
        line(1'b0, 2);
        ready = 1'b1;
        line(1'b0, 1);
      end
    end
    chk_cnt++; if (data !== ec || valid !== 1'b1) $display("FAIL ovf_third_load: got %h v=%b expected %h v=1", data, valid, ec); else pass_cnt++;
    line(1'b0, Gap);
    chk_cnt++; if (ovf_cnt - ovf0 !== 1) $display("FAIL ovf_third_no_ovf: got %0d expected 1", ovf_cnt - ovf0); else pass_cnt++;
    chk_cnt++; if (got.size() !== 2 || got[0] !== ea || got[1] !== ec) $display("FAIL ovf_order: got n=%0d expected %h,%h", got.size(), ea, ec); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [23:0] e;
    ready = 1'b0;
    send_word(24'hFFFFFF, 1'b0, e);
    for (int i = 0; i < 10; i++) send_bit(WS281xT1HCycles, 11);
    line(1'b1, 5);
    rst_n = 1'b0;
    line(1'b1, 3);
    chk_cnt++; if (data !== 24'h0 || valid !== 1'b0) $display("FAIL rstmid_data: got %h v=%b expected 000000 v=0", data, valid); else pass_cnt++;
    chk_cnt++; if ({frame_end, err, overflow} !== 3'b0) $display("FAIL rstmid_flags: got %b expected 000", {frame_end, err, overflow}); else pass_cnt++;
    din = 1'b0;
    rst_n = 1'b1;
    ready = 1'b1;
    got.delete();
    line(1'b0, 100);
    send_word(24'h00FF00, 1'b0, e);
    line(1'b0, Gap);
    chk_cnt++; if (got.size() !== 0) $display("FAIL rstmid_needs_gap: got %0d words expected 0", got.size()); else pass_cnt++;
    send_word(24'($urandom()), 1'b1, e);
    line(1'b0, Gap);
    chk_cnt++; if (got.size() !== 1 || got[0] !== e) $display("FAIL rstmid_word: got n=%0d expected %h", got.size(), e); else pass_cnt++;
  endtask

  initial begin
    logic [23:0] loop_words[2];
    logic [23:0] none[2];
    loop_words = '{24'h123456, 24'hFEDCBA};
    none = '{24'h0, 24'h0};
    test_reset();
    test_single_word();
    test_stream("loopback", 1'b0, 2, loop_words);
    test_stream("random", 1'b1, 4, none);
    test_boundaries();
    test_glitch_stuck();
    test_partial();
    test_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/ws281x_rx.md
# ws281x_rx

Single-wire WS281x (NeoPixel-style) receiver and decoder, the receive end of the protocol our `ws281x_drv` transmits. It samples an asynchronous serial line, classifies each high pulse as a 0 or 1 bit by width, and assembles bits MSB-first into 24-bit words. It detects the latch/reset gap as a frame boundary and presents each word on a valid/ready interface. It is used for driver loopback self-test and for daisy-chain pass-through, and sits in the same clock domain as the LED driver.

## Interface
Parameters:
- `BitThreshCycles`, default 15: high pulse of at least this many cycles decodes as 1, otherwise 0 (0.6 µs at 25 MHz).
- `MinHighCycles`, default 3: high pulse shorter than this is a glitch error.
- `MaxHighCycles`, default 50: high pulse longer than this is a stuck-high error.
- `ResetCycles`, default 1250: low time of at least this many cycles is a frame gap (50 µs at 25 MHz).
- Constraint: `MinHighCycles < BitThreshCycles <= MaxHighCycles < ResetCycles`. Enforced by elaboration assertion.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `din_i`, in, 1: serial line, asynchronous to `clk_i`.
- `data_o`, out, 24: decoded word; the first bit received is bit 23.
- `data_valid_o`, out, 1: `data_o` holds an unconsumed word.
- `data_ready_i`, in, 1: consumer accepts the word when it is high together with `data_valid_o`.
- `frame_end_o`, out, 1: one-cycle pulse when a reset gap is detected.
- `err_o`, out, 1: one-cycle pulse on a protocol error.
- `overflow_o`, out, 1: one-cycle pulse when a completed word is dropped.

## Operation
- Synchronise `din_i` with a 2-flop synchroniser. Keep `prev` as the last synchronised value. Rise = s & !prev; fall = !s & prev.
- Reset values: every output is 0, both synchroniser flops are 0, state is RESYNC, and all counters are 0.
- `hi_cnt` counts cycles while the line is high and saturates at `MaxHighCycles+1`. It clears on rise.
- `lo_cnt` counts cycles while the line is low and saturates at `ResetCycles`. It clears on fall.
- Counter width is `$clog2(ResetCycles+1)`.
- `bit_cnt` is 5 bits, range 0..23. `shreg` is 24 bits.
- RESYNC:
  - Stay while the line is high.
  - When `lo_cnt` reaches `ResetCycles`, go to IDLE and pulse `frame_end_o`.
  - No `err_o` is raised in RESYNC.
- IDLE:
  - Line low with `bit_cnt`=0. On rise, go to HIGH.
- HIGH: on fall, evaluate the width `w = hi_cnt` (inclusive of the current cycle).
  - If `w < MinHighCycles`: pulse `err_o`, clear `bit_cnt`, go to RESYNC.
  - Otherwise shift in (`w >= BitThreshCycles`), increment `bit_cnt`, and go to LOW.
  - On the 24th bit, deliver the word and set `bit_cnt` to 0.
  - If `hi_cnt` exceeds `MaxHighCycles` while still high, pulse `err_o` once, clear `bit_cnt`, and go to RESYNC.
- LOW:
  - On rise, go to HIGH.
  - When `lo_cnt` reaches `ResetCycles`, pulse `frame_end_o` and go to IDLE.
  - If `bit_cnt != 0` at that point, also pulse `err_o` and discard the partial bits.
- Word delivery:
  - If `data_valid_o` is 0, or is being accepted this cycle: load `data_o` and set `data_valid_o`.
  - Otherwise keep the old word, drop the new one, and pulse `overflow_o`.
- Acceptance with no concurrent delivery clears `data_valid_o`.
- Reset mid-word discards all state. After reset the block needs a full `ResetCycles` low period before it decodes anything.

## Timing
- Latency from the `din_i` edge to internal edge detection is 2 cycles (synchroniser).
- `data_valid_o` and the new `data_o` appear on the 3rd rising `clk_i` edge after the final falling `din_i` edge of a word, provided the falling edge meets setup before edge 1.
- `frame_end_o` pulses exactly `ResetCycles`+2 cycles after the last falling `din_i` edge.
- Pulse widths are measured in synchronised cycles, so the tolerance is ±1 cycle.
- Back-to-back words with bit period ≥ `MinHighCycles`+2 decode without loss, provided the consumer keeps `data_ready_i` high.
- `frame_end_o`, `err_o` and `overflow_o` can coincide, for example a partial frame followed by a gap.

## Structure
- Package `ws281x_pkg`:
  - state enum `ws281x_rx_state_e` (RESYNC, IDLE, HIGH, LOW);
  - `WS281xWordWidth` = 24;
  - default timing constants shared with `ws281x_drv`.
- Sub-module: `prim_flop_2sync` for `din_i`. No other hierarchy.

## Test plan
- **Single word:** after 1300 low cycles, send 0xA5C30F with T0H=10, T1H=20 and a 31-cycle period, then 1300 low cycles. Expect `data_o`=0xA5C30F with valid 3 cycles after the last fall, one `frame_end_o`, and no `err_o`.
- **Loopback:** drive from `ws281x_drv` with `data_i` = 0x123456 then 0xFEDCBA. Expect the receiver to output the same two words in order, with `data_ready_i` held high.
- **Glitch and stuck-high:** a 2-cycle high pulse gives an `err_o` pulse and RESYNC. Holding the line high for 60 cycles gives one `err_o` pulse, and no word until a 1250-cycle gap has passed.
- **Partial frame:** send 12 bits, then a gap. Expect `err_o` and `frame_end_o` in the same cycle, `data_valid_o` staying 0, and the next full word decoding correctly.
- **Overflow:** send two words with `data_ready_i`=0. Expect the first word retained and `overflow_o` pulsing once. Assert ready in the same cycle as the third word's completion; expect the third word loaded with no overflow.
- **Reset mid-word:** assert `rst_ni` after 10 bits. Expect all outputs 0, then a full 24-bit word after the gap decodes correctly.
